// File: rtl/hilo_mult_unit.sv
// rtl/hilo_mult_unit.sv - sequential signed shift-add multiplier driving the HI/LO register pair
// Define HILO_FAST_MULT_EN to replace the iterative RUN phase with a single-step multiply.
module hilo_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic             readHi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hiloOut
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_pend_hi;
    logic                 r_pend_lo;
    logic                 w_last;

`ifdef HILO_FAST_MULT_EN
    logic signed [2*WIDTH-1:0] w_fast_prod;

    assign w_fast_prod = $signed(opA) * $signed(opB);
    assign w_last      = 1'b0;
`else
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic                 r_sign;
    logic [CW-1:0]        r_count;
    logic [WIDTH:0]       w_abs_a;
    logic [WIDTH:0]       w_abs_b;
    logic [WIDTH:0]       w_upper_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_signed_res;

    // One extra bit so the most-negative operand's magnitude is representable.
    assign w_abs_a = opA[WIDTH-1] ? ({1'b0, ~opA} + {{WIDTH{1'b0}}, 1'b1}) : {1'b0, opA};
    assign w_abs_b = opB[WIDTH-1] ? ({1'b0, ~opB} + {{WIDTH{1'b0}}, 1'b1}) : {1'b0, opB};

    assign w_upper_sum  = r_acc[0] ? ({1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                                   : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_acc_next   = {w_upper_sum, r_acc[WIDTH-1:1]};
    assign w_signed_res = r_sign ? ({2*WIDTH{1'b0}} - w_acc_next) : w_acc_next;
    assign w_last       = (r_state == S_RUN) && (r_count == CW'(1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef HILO_FAST_MULT_EN
                    w_next = S_DONE;
`else
                    w_next = S_RUN;
`endif
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_product <= '0;
            r_pend_hi <= 1'b0;
            r_pend_lo <= 1'b0;
            hi        <= '0;
            lo        <= '0;
`ifndef HILO_FAST_MULT_EN
            r_acc     <= '0;
            r_mcand   <= '0;
            r_sign    <= 1'b0;
            r_count   <= '0;
`endif
        end else begin
            if (r_state == S_RUN) begin
                r_pend_hi <= r_pend_hi | hiWrite;
                r_pend_lo <= r_pend_lo | loWrite;
`ifndef HILO_FAST_MULT_EN
                r_acc     <= w_acc_next;
                r_count   <= r_count - 1'b1;
                if (w_last) begin
                    r_product <= w_signed_res;
                end
`endif
            end else begin
                // IDLE and DONE commit; pending flags are only ever set in RUN, so in IDLE they are 0.
                if (hiWrite || r_pend_hi) begin
                    hi <= r_product[2*WIDTH-1:WIDTH];
                end
                if (loWrite || r_pend_lo) begin
                    lo <= r_product[WIDTH-1:0];
                end
                r_pend_hi <= 1'b0;
                r_pend_lo <= 1'b0;
            end

            if (r_state == S_IDLE && start) begin
`ifdef HILO_FAST_MULT_EN
                r_product <= w_fast_prod;
`else
                r_mcand   <= w_abs_a[WIDTH-1:0];
                r_acc     <= {{WIDTH{1'b0}}, w_abs_b[WIDTH-1:0]};
                r_sign    <= opA[WIDTH-1] ^ opB[WIDTH-1];
                r_count   <= CW'(WIDTH);
`endif
            end
        end
    end

    assign hiloOut = readHi ? hi : lo;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb/tb_hilo_mult_unit.sv - self-checking bench for hilo_mult_unit against a signed-product model
module tb_hilo_mult_unit;
    localparam int W = 32;
`ifdef HILO_FAST_MULT_EN
    localparam int NRUN = 0;
`else
    localparam int NRUN = W;
`endif

    logic          clk = 1'b0;
    logic          reset, start, hiWrite, loWrite, readHi;
    logic [W-1:0]  opA, opB;
    logic          busy, done;
    logic [W-1:0]  hi, lo, hiloOut;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [W-1:0]  m_hi, m_lo;
    logic [2*W-1:0] m_prod;

    hilo_mult_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .opA(opA), .opB(opB),
        .hiWrite(hiWrite), .loWrite(loWrite), .readHi(readHi),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .hiloOut(hiloOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
    endtask

    // One full multiply: optional commits during RUN, in DONE, and in the IDLE cycle after.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit run_h, input bit run_l, input bit done_h, input bit done_l,
                            input bit after_h, input bit after_l, input bit start_l,
                            input int restart_at);
        logic [2*W-1:0] p;
        bit ph, pl;
        ph = 1'b0;
        pl = 1'b0;
        p  = 64'(longint'($signed(a)) * longint'($signed(b)));
        opA = a; opB = b; start = 1'b1; loWrite = start_l;
        tick();
        if (start_l) m_lo = m_prod[W-1:0];
        start = 1'b0; loWrite = 1'b0; opA = $urandom; opB = $urandom;
        for (int c = 1; c <= NRUN; c++) begin
            chk("busy_run", 64'(busy), 64'd1);
            chk("done_run", 64'(done), 64'd0);
            chk_regs("hold_run");
            if (c == 2) begin
                hiWrite = run_h; loWrite = run_l; ph = run_h; pl = run_l;
            end
            if (c == restart_at) begin
                start = 1'b1; opA = $urandom; opB = $urandom;
            end
            tick();
            hiWrite = 1'b0; loWrite = 1'b0; start = 1'b0;
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_done", 64'(busy), 64'd0);
        chk_regs("hold_done");
        hiWrite = done_h; loWrite = done_l; start = (restart_at != 0);
        tick();
        hiWrite = 1'b0; loWrite = 1'b0; start = 1'b0;
        if (ph || done_h) m_hi = p[2*W-1:W];
        if (pl || done_l) m_lo = p[W-1:0];
        m_prod = p;
        chk("done_clear", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk_regs("commit");
        if (after_h || after_l) begin
            hiWrite = after_h; loWrite = after_l;
            tick();
            hiWrite = 1'b0; loWrite = 1'b0;
            if (after_h) m_hi = p[2*W-1:W];
            if (after_l) m_lo = p[W-1:0];
            chk_regs("after");
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0; readHi = 1'b0;
        opA = '0; opB = '0;
        m_hi = '0; m_lo = '0; m_prod = '0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk_regs("rst");
        reset = 1'b0;
        tick();
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_out", 64'(hiloOut), 64'd0);

        run_mult(32'd6, 32'd7, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("basic_lo", 64'(lo), 64'h2A);
        chk("basic_hi", 64'(hi), 64'h0);

        run_mult(32'hFFFF_FFFD, 32'd5, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("mixed_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mixed_lo", 64'(lo), 64'hFFFF_FFF1);

        run_mult(32'h8000_0000, 32'h8000_0000, 0, 0, 1, 1, 0, 0, 0, 0);
        chk("maxneg_hi", 64'(hi), 64'h4000_0000);
        chk("maxneg_lo", 64'(lo), 64'h0);
        readHi = 1'b1; #1;
        chk("hilo_hi", 64'(hiloOut), 64'h4000_0000);
        readHi = 1'b0; #1;
        chk("hilo_lo", 64'(hiloOut), 64'h0);

        run_mult(-32'sd7, 32'd1000, 0, 0, 1, 0, 0, 0, 0, 10);
        chk("restart_hi", 64'(hi), 64'hFFFF_FFFF);

        run_mult(32'd9, 32'd9, 0, 0, 0, 0, 1, 1, 1, 0);
        chk("zero_start", 64'(lo), 64'd81);

        run_mult(32'd0, $urandom, 0, 1, 0, 0, 1, 0, 0, 0);
        chk("zero_lo", 64'(lo), 64'h0);

`ifndef HILO_FAST_MULT_EN
        opA = 32'd5; opB = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 15; c++) begin
            hiWrite = (c == 5);
            tick();
        end
        hiWrite = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0; m_prod = '0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk_regs("mid_rst");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mid_rst_quiet", 64'(done), 64'd0);
        end
        run_mult(-32'sd2, 32'd3, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("pend_cleared_hi", 64'(hi), 64'h0);
`endif
        run_mult(32'd2, 32'd3, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("after_rst_lo", 64'(lo), 64'd6);

        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("negneg_hi", 64'(hi), 64'h0);
        chk("negneg_lo", 64'(lo), 64'h1);

        for (int i = 0; i < 10; i++) begin
            run_mult($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, W)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
